// File: rtl/rca_seq_pkg.sv
// Shared constants, FSM state type and chunk-count helper for rca_seq_adder.
package rca_seq_pkg;
   localparam int CHUNK_W = 32;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int nchunk(input int width);
      return width / CHUNK_W;
   endfunction
endpackage

// File: rtl/rca_seq_adder_rca32.sv
// 32-bit ripple-carry adder; the single shared chunk datapath of rca_seq_adder.
module rca32 (
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Cin,
   output logic [31:0] S,
   output logic        Cout
);
   logic [32:0] c;

   assign c[0] = Cin;

   for (genvar i = 0; i < 32; i++) begin : g_fa
      assign S[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
   end

   assign Cout = c[32];
endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle WIDTH-bit adder: streams 32-bit chunks LSB-first through one rca32.
// Define RCA_SEQ_SUB_EN to add the op port (op=1 computes a-b).
module rca_seq_adder
   import rca_seq_pkg::*;
#(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
   input  logic             op,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int NCHUNK = nchunk(WIDTH);
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_bad_width
      $error("rca_seq_adder: WIDTH must be a non-zero multiple of 32");
   end

   state_t           state;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry_q, cout_q;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   logic [31:0]      add_a, add_b, add_s;
   logic             add_co;

   // Subtraction is folded in at accept time: store ~b and seed the carry with 1.
`ifdef RCA_SEQ_SUB_EN
   assign b_eff   = op ? ~b : b;
   assign cin_eff = op | cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   assign add_a = a_q[CHUNK_W*cnt +: CHUNK_W];
   assign add_b = b_q[CHUNK_W*cnt +: CHUNK_W];

   rca32 u_rca (
      .A    (add_a),
      .B    (add_b),
      .Cin  (carry_q),
      .S    (add_s),
      .Cout (add_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q     <= a;
               b_q     <= b_eff;
               carry_q <= cin_eff;
               cnt     <= '0;
               state   <= RUN;
            end
            RUN: begin
               sum_q[CHUNK_W*cnt +: CHUNK_W] <= add_s;
               carry_q <= add_co;
               if (cnt == LAST) begin
                  cout_q <= add_co;
                  cnt    <= '0;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // in_ready is gated by rst_n so nothing is offered while reset is held.
   assign in_ready  = rst_n && (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum       = sum_q;
   assign cout      = cout_q;
endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed self-checking bench for rca_seq_adder (WIDTH=128).
module tb_rca_seq_adder;
   localparam int W = 128;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic         cin;
`ifdef RCA_SEQ_SUB_EN
   logic         op;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int acc_q[$];

   rca_seq_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef RCA_SEQ_SUB_EN
      .op        (op),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Log the cycle of every accept handshake (sampled mid-cycle).
   always @(negedge clk) if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one op, check latency and result; completes the output handshake if out_ready=1.
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic [W-1:0] es, input logic ec);
      int n;
      @(negedge clk);
      a = ta; b = tb_; cin = tc; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_accept"}, in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk({tag, "_lat"}, n, 4);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      if (out_ready) begin
         @(posedge clk); #1;
         chk({tag, "_ovdrop"}, out_valid, 1'b0);
         chk({tag, "_irdy"}, in_ready, 1'b1);
      end
   endtask

   initial begin
      int n;
      logic [W-1:0] ones;
      ones = '1;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
`ifdef RCA_SEQ_SUB_EN
      op = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_irdy", in_ready, 1'b0);
      chk("rst_ovld", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sum", sum, '0);
      chk("rst_cout", cout, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rel_irdy", in_ready, 1'b1);

      run_op("carry_all", ones, 128'd1, 1'b0, '0, 1'b1);
      run_op("carry_bnd", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'd1, 1'b0,
             128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0);
      run_op("cin", '0, '0, 1'b1, 128'd1, 1'b0);
      run_op("max", ones, ones, 1'b1, ones, 1'b1);

      // Back-to-back with in_valid held high: accepts every 6 cycles.
      @(posedge clk); #1;
      acc_q.delete();
      a = 128'd5; b = 128'd6; cin = 1'b0; in_valid = 1'b1;
      n = 0;
      while (acc_q.size() < 3 && n < 40) begin @(posedge clk); #1; n++; end
      in_valid = 1'b0;
      chk("b2b_count", acc_q.size(), 3);
      if (acc_q.size() >= 3) begin
         chk("b2b_per0", acc_q[1] - acc_q[0], 6);
         chk("b2b_per1", acc_q[2] - acc_q[1], 6);
      end
      n = 0;
      while (busy && n < 40) begin @(posedge clk); #1; n++; end
      chk("b2b_idle", busy, 1'b0);
      chk("b2b_sum", sum, 128'd11);

      // Back-pressure in DONE.
      out_ready = 1'b0;
      run_op("bp", 128'h0123_4567_89AB_CDEF_0000_0001_FFFF_FFFF, 128'd1, 1'b0,
             128'h0123_4567_89AB_CDEF_0000_0002_0000_0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 128'(i + 100); b = 128'd9;
         @(posedge clk); #1;
         chk("bp_sum", sum, 128'h0123_4567_89AB_CDEF_0000_0002_0000_0000);
         chk("bp_cout", cout, 1'b0);
         chk("bp_ovld", out_valid, 1'b1);
         chk("bp_irdy", in_ready, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_rel_ovld", out_valid, 1'b0);
      chk("bp_rel_irdy", in_ready, 1'b1);

      // Reset during chunk 2.
      @(negedge clk);
      a = ones; b = 128'd1; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mrst_ovld", out_valid, 1'b0);
      chk("mrst_sum", sum, '0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_irdy", in_ready, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("mrst_rel_irdy", in_ready, 1'b1);
      run_op("post_rst", 128'd3, 128'd4, 1'b0, 128'd7, 1'b0);

`ifdef RCA_SEQ_SUB_EN
      op = 1'b1;
      run_op("sub_pos", 128'd7, 128'd5, 1'b0, 128'd2, 1'b1);
      run_op("sub_neg", 128'd5, 128'd7, 1'b1, ones - 128'd1, 1'b0);
      op = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
